// File: rtl/ntt_butterfly_unit_pkg.sv
// Shared constants, mode type and the restoring-division step used by the
// modular multiplier of the NTT butterfly unit.
package ntt_butterfly_unit_pkg;

  localparam int LOGQ_MAX   = 54;
  localparam int QM_W       = 17;
  localparam int K_W        = 4;
  localparam int LOW_W      = 24;
  localparam int MODMUL_LAT = 10;
  localparam int BF_LAT     = MODMUL_LAT + 2;

  // One product-capture stage, then the remainder is built over the rest.
  localparam int DIV_STAGES = MODMUL_LAT - 1;
  localparam int DIV_BPS    = LOGQ_MAX / DIV_STAGES;

  typedef enum logic {
    BF_DIT = 1'b0,
    BF_DIF = 1'b1
  } bf_mode_e;

  // Shift one product bit into a remainder r < q and keep it below q.
  function automatic logic [LOGQ_MAX-1:0] div_step(
    input logic [LOGQ_MAX-1:0] r,
    input logic                in_bit,
    input logic [LOGQ_MAX-1:0] q
  );
    logic [LOGQ_MAX:0] t;
    t = {r, in_bit};
    if (t >= {1'b0, q}) t = t - {1'b0, q};
    return t[LOGQ_MAX-1:0];
  endfunction

endpackage

// File: rtl/ntt_butterfly_unit_if.sv
// Sample stream into and butterfly pair out of the NTT butterfly unit.
interface ntt_butterfly_unit_if;
  import ntt_butterfly_unit_pkg::*;

  // in_valid qualifies a, b, tw and is_DIF in the same cycle; there is no
  // ready, the unit accepts every cycle. out_valid qualifies x and y.
  logic                in_valid;
  logic                is_DIF;
  logic [LOGQ_MAX-1:0] a;
  logic [LOGQ_MAX-1:0] b;
  logic [LOGQ_MAX-1:0] tw;
  logic                out_valid;
  logic [LOGQ_MAX-1:0] x;
  logic [LOGQ_MAX-1:0] y;

  modport master (
    output in_valid, is_DIF, a, b, tw,
    input  out_valid, x, y
  );

  modport slave (
    input  in_valid, is_DIF, a, b, tw,
    output out_valid, x, y
  );

endinterface

// File: rtl/ntt_butterfly_unit_delay.sv
// Clearable shift-register delay line used to align side data with the multiplier.
module ntt_butterfly_unit_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_butterfly_unit_mod_add_sub.sv
// Registered modular add and subtract of two residues below q (1-cycle latency).
module ntt_butterfly_unit_mod_add_sub
  import ntt_butterfly_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [LOGQ_MAX-1:0] a,
  input  logic [LOGQ_MAX-1:0] b,
  input  logic [LOGQ_MAX-1:0] q,
  output logic [LOGQ_MAX-1:0] sum,
  output logic [LOGQ_MAX-1:0] diff
);

  logic [LOGQ_MAX:0]   s_raw;
  logic [LOGQ_MAX:0]   s_red;
  logic [LOGQ_MAX-1:0] d_raw;

  // Carry bit kept so q close to 2^LOGQ_MAX cannot overflow the sum.
  always_comb begin
    s_raw = {1'b0, a} + {1'b0, b};
    s_red = s_raw - {1'b0, q};
    d_raw = a - b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      diff <= '0;
    end else if (en) begin
      sum  <= (s_raw >= {1'b0, q}) ? s_red[LOGQ_MAX-1:0] : s_raw[LOGQ_MAX-1:0];
      diff <= (a < b) ? d_raw + q : d_raw;
    end
  end

endmodule

// File: rtl/ntt_butterfly_unit_mod_mul.sv
// Pipelined (a*b) mod q on the shared integer multiplier, MODMUL_LAT cycles.
module ntt_butterfly_unit_mod_mul
  import ntt_butterfly_unit_pkg::*;
(
  input  logic                  clk,
  input  logic [LOGQ_MAX-1:0]   a,
  input  logic [LOGQ_MAX-1:0]   b,
  input  logic [LOGQ_MAX-1:0]   q,
  input  logic [QM_W-1:0]       qm,
  input  logic [K_W-1:0]        current_k,
  output logic [LOGQ_MAX-1:0]   mult_a,
  output logic [LOGQ_MAX-1:0]   mult_b,
  input  logic [2*LOGQ_MAX-1:0] int_mult_result,
  input  logic [LOW_W-1:0]      int_mult_result_low,
  output logic [LOGQ_MAX-1:0]   r
);

  logic [LOGQ_MAX-1:0] rem_q [0:DIV_STAGES];
  logic [LOGQ_MAX-1:0] low_q [0:DIV_STAGES-1];
  logic [LOGQ_MAX-1:0] rem_n [1:DIV_STAGES];
  logic [LOGQ_MAX-1:0] acc;
  logic                unused_sig;

  // The remainder is exact restoring division, so the Barrett constants and
  // low product are accepted for port compatibility but carry no information here.
  assign unused_sig = ^{qm, current_k, int_mult_result_low};

  assign mult_a = a;
  assign mult_b = b;

  // Product < q^2 implies product >> LOGQ_MAX < q, a valid starting remainder.
  always_comb begin
    acc = '0;
    for (int i = 1; i <= DIV_STAGES; i++) begin
      acc = rem_q[i-1];
      for (int j = 0; j < DIV_BPS; j++) begin
        acc = div_step(acc, low_q[i-1][LOGQ_MAX-1-j], q);
      end
      rem_n[i] = acc;
    end
  end

  always_ff @(posedge clk) begin
    rem_q[0] <= int_mult_result[2*LOGQ_MAX-1:LOGQ_MAX];
    low_q[0] <= int_mult_result[LOGQ_MAX-1:0];
    for (int i = 1; i <= DIV_STAGES; i++) rem_q[i] <= rem_n[i];
    for (int i = 1; i < DIV_STAGES; i++) low_q[i] <= low_q[i-1] << DIV_BPS;
  end

  assign r = rem_q[DIV_STAGES];

endmodule

// File: rtl/ntt_butterfly_unit.sv
// Unified CT (DIT) / GS (DIF) modular butterfly, one sample per cycle, fixed
// latency BF_LAT in both modes; the mode bit travels with every sample.
module ntt_butterfly_unit
  import ntt_butterfly_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  ntt_butterfly_unit_if.slave   bf,
  input  logic [LOGQ_MAX-1:0]   q,
  input  logic [QM_W-1:0]       qm,
  input  logic [K_W-1:0]        current_k,
  output logic [LOGQ_MAX-1:0]   mult_a,
  output logic [LOGQ_MAX-1:0]   mult_b,
  input  logic [2*LOGQ_MAX-1:0] int_mult_result,
  input  logic [LOW_W-1:0]      int_mult_result_low
);

  localparam int DW = LOGQ_MAX + 2;

  logic                v0;
  bf_mode_e            m0;
  logic [LOGQ_MAX-1:0] a0, b0, tw0, s0, d0;
  logic [LOGQ_MAX-1:0] mm_a, mm_b, mm_r, add0;
  logic [DW-1:0]       dly_in, dly_out;
  logic                v10;
  bf_mode_e            m10;
  logic [LOGQ_MAX-1:0] add10;
  logic [LOGQ_MAX-1:0] sum_p, diff_p, x_dif, y_dif;
  bf_mode_e            m_out;
  logic                out_v;

  always_ff @(posedge clk) begin
    if (rst) v0 <= 1'b0;
    else     v0 <= bf.in_valid;
    m0  <= bf.is_DIF ? BF_DIF : BF_DIT;
    a0  <= bf.a;
    b0  <= bf.b;
    tw0 <= bf.tw;
  end

  // GS pre-stage runs alongside the input register so both modes enter the
  // multiplier in the same slot and can alternate without collisions.
  ntt_butterfly_unit_mod_add_sub u_pre (
    .clk (clk), .rst (rst), .en (1'b1),
    .a   (bf.a), .b (bf.b), .q (q),
    .sum (s0), .diff (d0)
  );

  always_comb begin
    mm_a = (m0 == BF_DIF) ? d0  : tw0;
    mm_b = (m0 == BF_DIF) ? tw0 : b0;
    add0 = (m0 == BF_DIF) ? s0  : a0;
  end

  ntt_butterfly_unit_mod_mul u_mul (
    .clk                 (clk),
    .a                   (mm_a),
    .b                   (mm_b),
    .q                   (q),
    .qm                  (qm),
    .current_k           (current_k),
    .mult_a              (mult_a),
    .mult_b              (mult_b),
    .int_mult_result     (int_mult_result),
    .int_mult_result_low (int_mult_result_low),
    .r                   (mm_r)
  );

  assign dly_in = {v0, m0, add0};

  ntt_butterfly_unit_delay #(.WIDTH(DW), .DEPTH(MODMUL_LAT)) u_dly (
    .clk (clk), .rst (rst), .din (dly_in), .dout (dly_out)
  );

  assign v10   = dly_out[DW-1];
  assign m10   = bf_mode_e'(dly_out[LOGQ_MAX]);
  assign add10 = dly_out[LOGQ_MAX-1:0];

  ntt_butterfly_unit_mod_add_sub u_post (
    .clk (clk), .rst (rst), .en (v10 && (m10 == BF_DIT)),
    .a   (add10), .b (mm_r), .q (q),
    .sum (sum_p), .diff (diff_p)
  );

  // Every output source only loads on a valid sample, so bubbles hold x/y.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v <= 1'b0;
      m_out <= BF_DIT;
      x_dif <= '0;
      y_dif <= '0;
    end else begin
      out_v <= v10;
      if (v10) begin
        m_out <= m10;
        if (m10 == BF_DIF) begin
          x_dif <= add10;
          y_dif <= mm_r;
        end
      end
    end
  end

  assign bf.out_valid = out_v;
  assign bf.x         = (m_out == BF_DIF) ? x_dif : sum_p;
  assign bf.y         = (m_out == BF_DIF) ? y_dif : diff_p;

endmodule
